mux_rr_scheduler: RTL and testbench
===================================

Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares the 11-input, 40-bit registered select mux among its producers.
- Watches the per-source data-ready flags and drives the mux's one-hot select.
- Waits out the mux's registered latency, then captures the selected word and its ready bit into a holding register.
- Presents that word to one downstream consumer with a valid/ready handshake and returns a one-cycle ack to the serviced source.

Parameters:
N_SRC, 11, number of requesting sources (width of one-hot select)
DATA_W, 40, data word width
MUX_LAT, 1, registered latency of the mux in clock cycles (>=1)
TIMEOUT, 255, consumer-stall limit in cycles (used only with the optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N_SRC  per-source data-ready flags; bit 0 = source a ... bit 10 = source k
sel  output  N_SRC  one-hot select to mux; all zeros when idle
mux_out  input  DATA_W  mux data output
mux_ready  input  1  mux ready output (registered ready of the selected source)
ack  output  N_SRC  one-cycle one-hot pulse to the source whose word was captured
out_data  output  DATA_W  held word for consumer
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts when high with out_valid
timeout_err  output  1  sticky stall-timeout flag (tied 0 when the feature is absent)

Behaviour:
- Clock and reset: one clock, clk; reset is rst_n, asynchronous, active-low.
- Reset values: sel=0, ack=0, out_data=0, out_valid=0, timeout_err=0, state=IDLE, rr_ptr=0, lat_cnt=0.

State machine:
- IDLE:
  - Grant = first set bit of req, scanning upward from rr_ptr and wrapping N_SRC-1 -> 0.
  - If req != 0: register sel=onehot(grant), grant_idx=grant, lat_cnt=MUX_LAT, go to WAIT.
  - Else stay in IDLE with sel=0.
- WAIT:
  - sel is held stable.
  - While lat_cnt != 0, decrement it.
  - On the edge where lat_cnt == 0, sample mux_out and mux_ready.
    - If mux_ready=1: out_data<=mux_out, out_valid<=1, ack[grant_idx]<=1 for exactly one cycle, sel<=0, go to PRESENT.
    - If mux_ready=0 (source withdrew): sel<=0, no ack, rr_ptr unchanged, go to IDLE.
- PRESENT:
  - out_data and out_valid are held until out_valid && out_ready.
  - On that edge: out_valid<=0, rr_ptr<=grant_idx+1 (wraps to 0 after N_SRC-1), go to IDLE.

Timing and corner cases:
- Latency: a request seen in IDLE at edge E0 gives out_valid high after edge E0+MUX_LAT+1. With MUX_LAT=1, sel rises after E0 and out_valid rises after E2.
- Throughput: at most one word per MUX_LAT+3 cycles (IDLE, WAIT, PRESENT, zero-stall consumer).
- req changes during WAIT or PRESENT are ignored; only IDLE arbitrates.
- Simultaneous requests: the lowest index at or above rr_ptr wins. A source served this round becomes lowest priority.
- req bits with index >= N_SRC do not exist. The grant is always valid one-hot.
- Reset mid-transfer: an asserted rst_n drops the held word and any pending ack immediately. No ack is issued for it.

Optional Feature:
- Macro: MUX_RR_SCHED_TIMEOUT_EN.
- Defined:
  - A stall counter runs in PRESENT while out_ready=0.
  - Reaching TIMEOUT cycles drops the word, sets out_valid<=0, sets timeout_err<=1 (sticky until reset) and advances rr_ptr as if accepted.
  - The counter clears on entry to PRESENT.
- Undefined: no counter. PRESENT waits indefinitely; timeout_err is tied 0 and TIMEOUT is unused.

Decomposition:
- Shared package mux_sched_pkg holds:
  - state enum (IDLE, WAIT, PRESENT)
  - N_SRC and DATA_W defaults
  - function onehot(idx)
- One sub-module: rr_arbiter_core. It is combinational: inputs req and rr_ptr; outputs grant_idx, grant_vld.
- FSM, latency counter, holding register and timeout stay in mux_rr_scheduler.

Test Plan:
- Single request, stub mux with MUX_LAT=1:
  - Stimulus: req=11'b00000000100, mux returns 40'hC0FFEE0001 with mux_ready=1.
  - Required: sel=0x004 one cycle after; ack[2] pulse; out_valid after E2; out_data=0xC0FFEE0001.
- Round-robin fairness:
  - Stimulus: req=0x7FF held, out_ready=1.
  - Required: grant order 0,1,...,10,0 and ack pulses in that order.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles.
  - Required: out_data stable, out_valid high, no new sel. Raising out_ready gives acceptance, then IDLE.
- Withdrawn source:
  - Stimulus: req=0x001 to grant, then mux_ready=0 at sample.
  - Required: no ack, out_valid stays 0, next grant is source 0 again.
- Reset mid-PRESENT:
  - Stimulus: rst_n low during PRESENT.
  - Required: out_valid=0, sel=0, ack=0 immediately; after release, first grant is source 0.
- MUX_RR_SCHED_TIMEOUT_EN with TIMEOUT=8:
  - Stimulus: out_ready held 0.
  - Required: after 8 cycles out_valid drops, timeout_err=1 and stays 1.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler: FSM state encoding,
// default geometry and the one-hot select helper.
package mux_sched_pkg;

    localparam int unsigned N_SRC_DEF  = 11;
    localparam int unsigned DATA_W_DEF = 40;

    // Upper bound on the source count supported by the one-hot helper.
    localparam int unsigned MAX_SRC    = 32;
    localparam int unsigned MAX_IDX_W  = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        PRESENT = 2'd2
    } state_t;

    // One-hot vector with bit idx set; callers size-cast to their source count.
    function automatic logic [MAX_SRC-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin pick: first set req bit at or above rr_ptr,
// wrapping from N_SRC-1 back to 0.
module rr_arbiter_core
    import mux_sched_pkg::*;
#(
    parameter int unsigned N_SRC = N_SRC_DEF,
    parameter int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    int unsigned w_pos;

    // Scan N_SRC positions starting at rr_ptr; the first hit wins.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        w_pos     = 0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            w_pos = 32'(rr_ptr) + k;
            if (w_pos >= N_SRC) begin
                w_pos = w_pos - N_SRC;
            end
            if (!grant_vld && req[w_pos]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler in front of a registered N_SRC-input select mux.
// Arbitrates in IDLE, waits out the mux latency in WAIT, then holds the
// captured word for a valid/ready consumer in PRESENT.
// Optional consumer-stall timeout: define MUX_RR_SCHED_TIMEOUT_EN.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int unsigned N_SRC   = N_SRC_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MUX_LAT = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SRC-1:0]  req,
    output logic [N_SRC-1:0]  sel,
    input  logic [DATA_W-1:0] mux_out,
    input  logic              mux_ready,
    output logic [N_SRC-1:0]  ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              timeout_err
);

    localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned LAT_W = $clog2(MUX_LAT + 1);

    if (MUX_LAT < 1 || TIMEOUT < 1 || N_SRC < 1 || N_SRC > MAX_SRC) begin : g_param_check
        $error("mux_rr_scheduler: unsupported parameter set");
    end

    state_t              r_state;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_grant_idx;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [N_SRC-1:0]    r_sel;
    logic [N_SRC-1:0]    r_ack;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;

    logic [IDX_W-1:0]    w_grant_idx;
    logic                w_grant_vld;
    logic [N_SRC-1:0]    w_grant_sel;
    logic [IDX_W-1:0]    w_next_ptr;

`ifdef MUX_RR_SCHED_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0]  r_stall_cnt;
    logic                r_timeout_err;
`endif

    rr_arbiter_core #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req),
        .rr_ptr    (r_rr_ptr),
        .grant_idx (w_grant_idx),
        .grant_vld (w_grant_vld)
    );

    assign w_grant_sel = N_SRC'(onehot(MAX_IDX_W'(w_grant_idx)));
    assign w_next_ptr  = (r_grant_idx == IDX_W'(N_SRC - 1)) ? '0 : r_grant_idx + 1'b1;

    // Scheduler FSM with registered select, ack pulse and holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_lat_cnt   <= '0;
            r_sel       <= '0;
            r_ack       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
`ifdef MUX_RR_SCHED_TIMEOUT_EN
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_grant_vld) begin
                        r_sel       <= w_grant_sel;
                        r_grant_idx <= w_grant_idx;
                        r_lat_cnt   <= LAT_W'(MUX_LAT);
                        r_state     <= WAIT;
                    end else begin
                        r_sel <= '0;
                    end
                end
                WAIT: begin
                    if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end else begin
                        r_sel <= '0;
                        if (mux_ready) begin
                            r_out_data  <= mux_out;
                            r_out_valid <= 1'b1;
                            r_ack       <= r_sel;
`ifdef MUX_RR_SCHED_TIMEOUT_EN
                            r_stall_cnt <= '0;
`endif
                            r_state     <= PRESENT;
                        end else begin
                            // Source withdrew: no ack and the pointer stays put.
                            r_state <= IDLE;
                        end
                    end
                end
                PRESENT: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_rr_ptr    <= w_next_ptr;
                        r_state     <= IDLE;
                    end
`ifdef MUX_RR_SCHED_TIMEOUT_EN
                    else if (r_stall_cnt == STALL_W'(TIMEOUT - 1)) begin
                        r_out_valid   <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_rr_ptr      <= w_next_ptr;
                        r_state       <= IDLE;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sel       = r_sel;
    assign ack       = r_ack;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

`ifdef MUX_RR_SCHED_TIMEOUT_EN
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler with a registered stub mux (MUX_LAT=1).
module tb_mux_rr_scheduler;

    localparam int unsigned N_SRC  = 11;
    localparam int unsigned DATA_W = 40;

    logic              clk;
    logic              rst_n;
    logic [N_SRC-1:0]  req;
    logic [N_SRC-1:0]  sel;
    logic [DATA_W-1:0] mux_out;
    logic              mux_ready;
    logic [N_SRC-1:0]  ack;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              timeout_err;

    logic [DATA_W-1:0] src_data [N_SRC];
    logic [N_SRC-1:0]  src_rdy;

    int errors = 0;
    int checks = 0;

    mux_rr_scheduler #(
        .N_SRC   (N_SRC),
        .DATA_W  (DATA_W),
        .MUX_LAT (1),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .sel         (sel),
        .mux_out     (mux_out),
        .mux_ready   (mux_ready),
        .ack         (ack),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered stub mux: one cycle from sel to data/ready.
    always @(posedge clk) begin
        logic [DATA_W-1:0] d;
        logic              r;
        d = '0;
        r = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel[i]) begin
                d = src_data[i];
                r = src_rdy[i];
            end
        end
        mux_out   <= d;
        mux_ready <= r;
    end

    typedef struct {
        logic [N_SRC-1:0]  req;
        logic [N_SRC-1:0]  exp_sel;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // One full transaction with a zero-stall consumer; called with the DUT in IDLE.
    task automatic run_vec(input vec_t v);
        req       = v.req;
        out_ready = 1'b1;
        tick();
        check("sel_grant", 64'(sel), 64'(v.exp_sel));
        check("ack_quiet_e0", 64'(ack), 64'd0);
        req = '0;
        tick();
        check("sel_hold", 64'(sel), 64'(v.exp_sel));
        check("valid_e1", 64'(out_valid), 64'd0);
        tick();
        check("valid_e2", 64'(out_valid), 64'd1);
        check("data_e2", 64'(out_data), 64'(v.exp_data));
        check("ack_pulse", 64'(ack), 64'(v.exp_sel));
        check("sel_clear", 64'(sel), 64'd0);
        tick();
        check("valid_accept", 64'(out_valid), 64'd0);
        check("ack_one_cycle", 64'(ack), 64'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] held;
        int                bad;
        int                got [$];
        int                stall_cyc;
        vec_t              v5;

        for (int i = 0; i < N_SRC; i++) begin
            src_data[i] = {32'hD00DF00D, 8'(i)};
        end
        src_data[2] = 40'hC0FFEE0001;
        src_rdy     = '1;

        // rr_ptr history: 0 ->3 ->2 ->3 ->0 ->1 ->5 ->6 ->7 ->1
        vecs[0] = '{11'h004, 11'h004, 40'hC0FFEE0001};
        vecs[1] = '{11'h006, 11'h002, 40'hD00DF00D01};
        vecs[2] = '{11'h006, 11'h004, 40'hC0FFEE0001};
        vecs[3] = '{11'h401, 11'h400, 40'hD00DF00D0A};
        vecs[4] = '{11'h401, 11'h001, 40'hD00DF00D00};
        vecs[5] = '{11'h0F0, 11'h010, 40'hD00DF00D04};
        vecs[6] = '{11'h7FF, 11'h020, 40'hD00DF00D05};
        vecs[7] = '{11'h041, 11'h040, 40'hD00DF00D06};
        vecs[8] = '{11'h041, 11'h001, 40'hD00DF00D00};

        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_sel", 64'(sel), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_sel", 64'(sel), 64'd0);

        // Table-driven arbitration sequence
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // Fairness: all sources requesting, grants rotate 0..10,0
        do_reset();
        req       = 11'h7FF;
        out_ready = 1'b1;
        for (int c = 0; c < 80 && got.size() < 12; c++) begin
            tick();
            if (ack != '0) begin
                check("fair_ack_onehot", 64'($countones(ack)), 64'd1);
                for (int b = 0; b < N_SRC; b++) begin
                    if (ack[b]) got.push_back(b);
                end
            end
        end
        req = '0;
        check("fair_ack_count", 64'(got.size()), 64'd12);
        for (int i = 0; i < got.size() && i < 12; i++) begin
            check("fair_order", 64'(got[i]), 64'(i % N_SRC));
        end

        // Backpressure: word held, no new select while stalled
        do_reset();
`ifdef MUX_RR_SCHED_TIMEOUT_EN
        stall_cyc = 6;
`else
        stall_cyc = 20;
`endif
        req       = 11'h010;
        out_ready = 1'b0;
        tick();
        check("bp_sel", 64'(sel), 64'h010);
        req = 11'h7FF;
        tick();
        tick();
        check("bp_valid", 64'(out_valid), 64'd1);
        held = out_data;
        check("bp_data", 64'(held), 64'h00D00DF00D04);
        bad = 0;
        for (int c = 0; c < stall_cyc; c++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== held || sel !== '0 || ack !== '0) bad++;
        end
        check("bp_stable", 64'(bad), 64'd0);
        check("bp_no_timeout", 64'(timeout_err), 64'd0);
        out_ready = 1'b1;
        tick();
        check("bp_accept", 64'(out_valid), 64'd0);
        tick();
        check("bp_next_grant", 64'(sel), 64'h020);
        req = '0;

        // Withdrawn source: no ack, pointer unchanged
        do_reset();
        src_rdy[0] = 1'b0;
        req        = 11'h001;
        out_ready  = 1'b1;
        tick();
        check("wd_sel", 64'(sel), 64'h001);
        req = '0;
        tick();
        tick();
        check("wd_valid", 64'(out_valid), 64'd0);
        check("wd_ack", 64'(ack), 64'd0);
        check("wd_sel_clear", 64'(sel), 64'd0);
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (ack !== '0 || out_valid !== 1'b0) bad++;
        end
        check("wd_quiet", 64'(bad), 64'd0);
        src_rdy[0] = 1'b1;
        req        = 11'h003;
        tick();
        check("wd_regrant", 64'(sel), 64'h001);
        req = '0;
        tick();
        tick();
        check("wd_regrant_ack", 64'(ack), 64'h001);
        check("wd_regrant_data", 64'(out_data), 64'h00D00DF00D00);
        tick();

        // Reset mid-PRESENT while the ack pulse is high
        do_reset();
        v5 = '{11'h020, 11'h020, 40'hD00DF00D05};
        run_vec(v5);
        req       = 11'h100;
        out_ready = 1'b0;
        tick();
        check("mr_sel", 64'(sel), 64'h100);
        req = '0;
        tick();
        tick();
        check("mr_ack_before", 64'(ack), 64'h100);
        check("mr_valid_before", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_sel_zero", 64'(sel), 64'd0);
        check("mr_ack_zero", 64'(ack), 64'd0);
        check("mr_data_zero", 64'(out_data), 64'd0);
        tick();
        rst_n     = 1'b1;
        req       = 11'h7FF;
        out_ready = 1'b1;
        tick();
        check("mr_first_grant", 64'(sel), 64'h001);
        req = '0;
        tick();
        tick();
        check("mr_first_ack", 64'(ack), 64'h001);
        tick();

`ifdef MUX_RR_SCHED_TIMEOUT_EN
        // Stall timeout: word dropped after 8 stalled cycles, flag sticky
        do_reset();
        req       = 11'h008;
        out_ready = 1'b0;
        tick();
        req = '0;
        tick();
        tick();
        check("to_valid", 64'(out_valid), 64'd1);
        for (int c = 0; c < 7; c++) tick();
        check("to_valid_held", 64'(out_valid), 64'd1);
        check("to_err_early", 64'(timeout_err), 64'd0);
        tick();
        check("to_valid_drop", 64'(out_valid), 64'd0);
        check("to_err_set", 64'(timeout_err), 64'd1);
        req       = 11'h018;
        out_ready = 1'b1;
        tick();
        check("to_ptr_adv", 64'(sel), 64'h010);
        req = '0;
        tick();
        tick();
        tick();
        check("to_err_sticky", 64'(timeout_err), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
